// File: rtl/param_fifo_out.sv
// Parametrised synchronous output FIFO with registered read data, occupancy
// count, full/empty flags and per-request ack/error pulses.
module param_fifo_out #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   d_in,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   d_out,
  output logic                full,
  output logic                empty,
  output logic                wr_ack,
  output logic                wr_err,
  output logic                rd_ack,
  output logic                rd_err,
  output logic [ADDR_W:0]     data_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_err_q, rd_err_d;

  logic full_c, empty_c, wr_accept, rd_accept;

  // Count is authoritative for full/empty; pointers may be equal in both cases.
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    empty_c   = (count_q == '0);
    wr_accept = wr_en & ~full_c;
    rd_accept = rd_en & ~empty_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;
    wr_ack_d = wr_accept;
    wr_err_d = wr_en & full_c;
    rd_ack_d = rd_accept;
    rd_err_d = rd_en & empty_c;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      d_out_d  = mem_q[rd_ptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      d_out_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= d_in;
  end

  assign d_out      = d_out_q;
  assign full       = full_c;
  assign empty      = empty_c;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign data_count = count_q;

endmodule

// File: tb/tb_param_fifo_out.sv
// Bench for param_fifo_out (DEPTH=8): directed plan followed by random traffic,
// all checked against a queue-based reference model.
module tb_param_fifo_out;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] d_in = '0;
  logic [DATA_W-1:0] d_out;
  logic              full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [ADDR_W:0]   data_count;

  param_fifo_out #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic exp_wr_ack = 0, exp_wr_err = 0, exp_rd_ack = 0, exp_rd_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":d_out"},      64'(d_out),      64'(exp_dout));
    chk({tag, ":count"},      64'(data_count), 64'(q.size()));
    chk({tag, ":full"},       64'(full),       64'(q.size() == DEPTH));
    chk({tag, ":empty"},      64'(empty),      64'(q.size() == 0));
    chk({tag, ":wr_ack"},     64'(wr_ack),     64'(exp_wr_ack));
    chk({tag, ":wr_err"},     64'(wr_err),     64'(exp_wr_err));
    chk({tag, ":rd_ack"},     64'(rd_ack),     64'(exp_rd_ack));
    chk({tag, ":rd_err"},     64'(rd_err),     64'(exp_rd_err));
  endtask

  // One clock cycle of requests; model decides on pre-edge occupancy.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [DATA_W-1:0] din);
    bit was_full, was_empty, wa, ra;
    wr_en = wr; rd_en = rd; d_in = din;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wa = wr && !was_full;
    ra = rd && !was_empty;
    @(posedge clk);
    #1;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(din);
    exp_wr_ack = wa;
    exp_wr_err = wr && was_full;
    exp_rd_ack = ra;
    exp_rd_err = rd && was_empty;
    wr_en = 0; rd_en = 0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_wr_ack = 0; exp_wr_err = 0; exp_rd_ack = 0; exp_rd_err = 0;
  endtask

  initial begin
    // 1. Reset held with a write pending
    reset_n = 0; wr_en = 1; d_in = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset_hold");
    wr_en = 0;
    @(negedge clk);
    reset_n = 1;
    step("post_reset_idle", 0, 0, '0);

    // 2. Fill to full, then overflow attempt
    for (int i = 0; i < 8; i++) step("fill", 1, 0, 32'h10 + 32'(i));
    step("overflow", 1, 0, 32'h99);

    // 3. Drain in order, then underflow attempt
    for (int i = 0; i < 8; i++) step("drain", 0, 1, '0);
    step("underflow", 0, 1, '0);
    step("idle_hold", 0, 0, '0);

    // 4. Wrap-around
    for (int i = 0; i < 5; i++) step("wrap_w5", 1, 0, 32'h30 + 32'(i));
    for (int i = 0; i < 5; i++) step("wrap_r5", 0, 1, '0);
    for (int i = 0; i < 8; i++) step("wrap_w8", 1, 0, 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) step("wrap_r8", 0, 1, '0);

    // 5. Simultaneous at empty, then read back
    step("both_empty", 1, 1, 32'h55);
    step("read_55", 0, 1, '0);

    // 6. Simultaneous at full, then mid-stream, then async reset
    for (int i = 0; i < 8; i++) step("refill", 1, 0, 32'h10 + 32'(i));
    step("both_full", 1, 1, 32'hEE);
    for (int i = 0; i < 4; i++) step("to_three", 0, 1, '0);
    step("both_mid", 1, 1, 32'h77);
    wr_en = 1; rd_en = 1; d_in = 32'h1234;
    reset_n = 0;
    #2;
    model_reset();
    check_all("async_reset");
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    reset_n = 1;
    step("after_async", 0, 0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      int bias;
      bias = (i / 50) % 2 == 0 ? 70 : 30;
      w = ($urandom_range(99) < bias);
      r = ($urandom_range(99) < (100 - bias));
      step("random", w, r, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fifo_out.md
Name: param_fifo_out

Overview:
- Parametrised synchronous FIFO that generalises the fixed 32-entry x 32-bit register-file read path.
- Adds registered read data, a write port, wrap-around read/write pointers, an occupancy count, full/empty flags, and per-request ack/error pulses.
- Sits between the factorial core's result producer and the bus/output interface, as the output buffering stage.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, pointer width; DEPTH = 2**ADDR_W entries (default 32)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
d_in  input  DATA_W  write data
rd_en  input  1  read request
d_out  output  DATA_W  registered read data, holds last read word
full  output  1  count == DEPTH (combinational from count)
empty  output  1  count == 0 (combinational from count)
wr_ack  output  1  one-cycle pulse, previous-cycle write accepted
wr_err  output  1  one-cycle pulse, previous-cycle write rejected (full)
rd_ack  output  1  one-cycle pulse, previous-cycle read accepted, d_out valid
rd_err  output  1  one-cycle pulse, previous-cycle read rejected (empty)
data_count  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - d_out goes to 0; wr_ack, wr_err, rd_ack, rd_err go to 0.
  - empty=1, full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
  - First request is sampled at the first rising edge after reset_n deasserts.
- Flags sampled for a decision are always the pre-edge values of full/empty.
- Write, wr_en=1 and full=0:
  - mem[wr_ptr] <= d_in.
  - wr_ptr <= wr_ptr+1, mod DEPTH with natural wrap.
  - wr_ack=1 next cycle.
- Write, wr_en=1 and full=1: no state change; wr_err=1 next cycle.
- Read, rd_en=1 and empty=0:
  - d_out <= mem[rd_ptr], so latency is 1 cycle from request to data.
  - rd_ptr <= rd_ptr+1, mod DEPTH.
  - rd_ack=1 next cycle.
- Read, rd_en=1 and empty=1: d_out holds; rd_err=1 next cycle.
- No request: all four pulses return to 0 in the next cycle. d_out holds its value indefinitely.
- Count update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both or neither are accepted.
  - count never exceeds DEPTH and never underflows.
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both accepted; count unchanged; wr_ack=rd_ack=1.
  - Full: read accepted, write rejected (wr_err=1, rd_ack=1); count goes DEPTH-1. No write-through.
  - Empty: write accepted, read rejected (wr_ack=1, rd_err=1); count goes 1. No fall-through; d_out does not show d_in.
- Pointer wrap: wr_ptr == rd_ptr with count==DEPTH means full, with count==0 means empty. Count, not pointer compare, is authoritative.
- Ack and error for the same port are never asserted together.
- Read and write of the same address in one cycle cannot occur: the read sees old data only in the full case, where the write is rejected.

Test Plan:
(Benches use ADDR_W=3, DEPTH=8, DATA_W=32.)
1. Reset check: hold reset_n=0 with wr_en=1 -> d_out=0, empty=1, full=0, data_count=0, all pulses 0; then release reset_n -> FIFO still empty.
2. Fill to full: write 0x10..0x17 on 8 consecutive cycles -> wr_ack each cycle, full=1 and data_count=8 after the 8th write. A 9th write of 0x99 -> wr_err=1 and data_count stays 8.
3. Drain in order: read 8 times from the full FIFO -> d_out = 0x10..0x17 one cycle after each rd_en, rd_ack each cycle, empty=1 at the end. A 9th read -> rd_err=1 and d_out holds 0x17.
4. Wrap-around: write 5, read 5, then write 0xA0..0xA7 and read all 8 -> data returns in order 0xA0..0xA7 across the pointer wrap; data_count goes 8 then 0.
5. Simultaneous at empty: wr_en=rd_en=1 with d_in=0x55 -> wr_ack=1, rd_err=1, data_count=1, d_out unchanged. Next read -> d_out=0x55.
6. Simultaneous at full, then mid-stream: with 8 entries 0x10..0x17, assert both with d_in=0xEE -> rd_ack=1 with d_out=0x10, wr_err=1, data_count=7. Then, at data_count=3, assert both with d_in=0x77 -> data_count stays 3, wr_ack=rd_ack=1. Assert reset_n=0 mid-stream -> data_count=0 and d_out=0 immediately.
